// File: rtl/insn_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads over a req/rdy
// handshake and drives the IF/ID register, honouring stall, flush and branches.
module insn_fetch #(
   parameter int                 ADDR_W       = 30,
   parameter int                 DATA_W       = 32,
   parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
   parameter logic [DATA_W-1:0]  NOP_INSN     = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rdy,
   input  logic [DATA_W-1:0] imem_rd_data,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_insn,
   output logic              if_en,
   output logic              busy
);

   typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HOLD} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_tgt;
   logic [ADDR_W-1:0] r_bpc;
   logic [DATA_W-1:0] r_buf;
   logic [ADDR_W-1:0] r_if_pc;
   logic [DATA_W-1:0] r_if_insn;
   logic              r_if_en;

   logic              w_req;
   logic              w_redirect;
   logic [ADDR_W-1:0] w_target;
   logic [ADDR_W-1:0] w_pc_inc;

   // The request drops combinationally with reset so nothing stays in flight.
   assign w_req      = reset & (r_state != S_HOLD);
   assign w_redirect = flush | (br_taken & r_if_en & ~stall);
   assign w_target   = flush ? new_pc : br_addr;
   assign w_pc_inc   = r_pc + ADDR_W'(1);

   assign imem_req  = w_req;
   assign imem_addr = r_pc;
   assign busy      = w_req & ~imem_rdy;
   assign if_pc     = r_if_pc;
   assign if_insn   = r_if_insn;
   assign if_en     = r_if_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_VECTOR;
         r_tgt     <= '0;
         r_bpc     <= '0;
         r_buf     <= '0;
         r_if_pc   <= '0;
         r_if_insn <= NOP_INSN;
         r_if_en   <= 1'b0;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (w_redirect) begin
                  r_if_en   <= 1'b0;
                  r_if_insn <= NOP_INSN;
                  if (imem_rdy) begin
                     r_pc <= w_target;
                  end else begin
                     r_tgt   <= w_target;
                     r_state <= S_DISCARD;
                  end
               end else if (stall) begin
                  if (imem_rdy) begin
                     r_buf   <= imem_rd_data;
                     r_bpc   <= r_pc;
                     r_pc    <= w_pc_inc;
                     r_state <= S_HOLD;
                  end
               end else if (imem_rdy) begin
                  r_if_pc   <= r_pc;
                  r_if_insn <= imem_rd_data;
                  r_if_en   <= 1'b1;
                  r_pc      <= w_pc_inc;
               end else begin
                  r_if_en   <= 1'b0;
                  r_if_insn <= NOP_INSN;
               end
            end
            // The old request must still complete; a later flush retargets it.
            S_DISCARD: begin
               r_if_en <= 1'b0;
               if (flush) begin
                  r_tgt <= new_pc;
               end
               if (imem_rdy) begin
                  r_pc    <= flush ? new_pc : r_tgt;
                  r_state <= S_FETCH;
               end
            end
            S_HOLD: begin
               if (flush) begin
                  r_if_en <= 1'b0;
                  r_pc    <= new_pc;
                  r_state <= S_FETCH;
               end else if (!stall) begin
                  if (br_taken && r_if_en) begin
                     r_if_en <= 1'b0;
                     r_pc    <= br_addr;
                  end else begin
                     r_if_pc   <= r_bpc;
                     r_if_insn <= r_buf;
                     r_if_en   <= 1'b1;
                  end
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_insn_fetch.sv
// Table-driven bench for insn_fetch: memory returns addr+0x100, each vector
// checks handshake outputs before the edge and IF/ID contents after it.
module tb_insn_fetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [29:0] new_pc;
   logic        br_taken;
   logic [29:0] br_addr;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rd_data;
   logic [29:0] if_pc;
   logic [31:0] if_insn;
   logic        if_en;
   logic        busy;

   int passCount;
   int totalCount;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        br;
      logic [29:0] brAddr;
      logic [29:0] newPc;
      logic        rdy;
      logic        req;
      logic [29:0] addr;
      logic        busy;
      logic        en;
      logic [29:0] pc;
      logic [31:0] insn;
   } vec_t;

   vec_t vecs[$];

   insn_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .br_taken     (br_taken),
      .br_addr      (br_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdy     (imem_rdy),
      .imem_rd_data (imem_rd_data),
      .if_pc        (if_pc),
      .if_insn      (if_insn),
      .if_en        (if_en),
      .busy         (busy)
   );

   // Memory model: the word at address A holds A + 0x100.
   assign imem_rd_data = 32'(imem_addr) + 32'h100;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      else
         passCount++;
   endtask

   function automatic vec_t mk(input logic st, input logic fl, input logic br, input logic [29:0] ba,
                               input logic [29:0] np, input logic rdy, input logic req,
                               input logic [29:0] addr, input logic bsy, input logic en,
                               input logic [29:0] pc, input logic [31:0] insn);
      vec_t v;
      v.stall = st; v.flush = fl; v.br = br; v.brAddr = ba; v.newPc = np; v.rdy = rdy;
      v.req = req; v.addr = addr; v.busy = bsy; v.en = en; v.pc = pc; v.insn = insn;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v, input int idx);
      stall    = v.stall;
      flush    = v.flush;
      br_taken = v.br;
      br_addr  = v.brAddr;
      new_pc   = v.newPc;
      imem_rdy = v.rdy;
      #1;
      checkOutput($sformatf("v%0d imem_req", idx), 32'(imem_req), 32'(v.req));
      checkOutput($sformatf("v%0d imem_addr", idx), 32'(imem_addr), 32'(v.addr));
      checkOutput($sformatf("v%0d busy", idx), 32'(busy), 32'(v.busy));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d if_en", idx), 32'(if_en), 32'(v.en));
      checkOutput($sformatf("v%0d if_pc", idx), 32'(if_pc), 32'(v.pc));
      checkOutput($sformatf("v%0d if_insn", idx), if_insn, v.insn);
   endtask

   initial begin
      passCount = 0;
      totalCount = 0;
      reset = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = '0;
      br_taken = 1'b0; br_addr = '0; imem_rdy = 1'b0;

      //         st fl br brAddr        newPc         rdy req addr          bsy en pc            insn
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 1, 30'h0,        1, 0, 30'h0,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h0,        0, 1, 30'h0,        32'h100));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h1,        0, 1, 30'h1,        32'h101));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h2,        0, 1, 30'h2,        32'h102));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h3,        0, 1, 30'h3,        32'h103));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h4,        0, 1, 30'h4,        32'h104));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 1, 30'h5,        1, 0, 30'h4,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 1, 30'h5,        1, 0, 30'h4,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 1, 30'h5,        1, 0, 30'h4,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h5,        0, 1, 30'h5,        32'h105));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h6,        0, 1, 30'h6,        32'h106));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h7,        0, 1, 30'h7,        32'h107));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        1, 1, 30'h8,        0, 1, 30'h7,        32'h107));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        0, 0, 30'h9,        0, 1, 30'h7,        32'h107));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        0, 0, 30'h9,        0, 1, 30'h7,        32'h107));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        0, 0, 30'h9,        0, 1, 30'h7,        32'h107));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 0, 30'h9,        0, 1, 30'h8,        32'h108));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h9,        0, 1, 30'h9,        32'h109));
      vecs.push_back(mk(0, 1, 0, 30'h0,  30'h2,        1, 1, 30'hA,        0, 0, 30'h9,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h2,        0, 1, 30'h2,        32'h102));
      vecs.push_back(mk(0, 0, 1, 30'h40, 30'h0,        0, 1, 30'h3,        1, 0, 30'h2,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 1, 30'h3,        1, 0, 30'h2,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h3,        0, 0, 30'h2,        32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h40,       0, 1, 30'h40,       32'h140));
      vecs.push_back(mk(0, 1, 0, 30'h0,  30'h10,       0, 1, 30'h41,       1, 0, 30'h40,       32'h0));
      vecs.push_back(mk(0, 1, 0, 30'h0,  30'h20,       0, 1, 30'h41,       1, 0, 30'h40,       32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h41,       0, 0, 30'h40,       32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h20,       0, 1, 30'h20,       32'h120));
      vecs.push_back(mk(0, 1, 0, 30'h0,  30'h3FFFFFFF, 1, 1, 30'h21,       0, 0, 30'h20,       32'h0));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h3FFFFFFF, 0, 1, 30'h3FFFFFFF, 32'h400000FF));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h0,        0, 1, 30'h0,        32'h100));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        1, 1, 30'h1,        0, 1, 30'h0,        32'h100));
      vecs.push_back(mk(1, 1, 0, 30'h0,  30'h30,       0, 0, 30'h2,        0, 0, 30'h0,        32'h100));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h30,       0, 1, 30'h30,       32'h130));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        1, 1, 30'h31,       0, 1, 30'h30,       32'h130));
      vecs.push_back(mk(0, 0, 1, 30'h50, 30'h0,        0, 0, 30'h32,       0, 0, 30'h30,       32'h130));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h50,       0, 1, 30'h50,       32'h150));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        0, 1, 30'h51,       1, 1, 30'h50,       32'h150));
      vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,        1, 1, 30'h51,       0, 1, 30'h50,       32'h150));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        0, 0, 30'h52,       0, 1, 30'h51,       32'h151));
      vecs.push_back(mk(1, 0, 1, 30'h60, 30'h0,        0, 1, 30'h52,       1, 1, 30'h51,       32'h151));
      vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,        1, 1, 30'h52,       0, 1, 30'h52,       32'h152));

      // Reset state while reset is held low
      #2;
      checkOutput("reset imem_req", 32'(imem_req), 32'h0);
      checkOutput("reset imem_addr", 32'(imem_addr), 32'h0);
      checkOutput("reset if_en", 32'(if_en), 32'h0);
      checkOutput("reset if_pc", 32'(if_pc), 32'h0);
      checkOutput("reset if_insn", if_insn, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i], i);

      // Reset asserted while a request is waiting for rdy
      stall = 1'b0; flush = 1'b0; br_taken = 1'b0; imem_rdy = 1'b0;
      #1;
      checkOutput("midwait imem_req", 32'(imem_req), 32'h1);
      checkOutput("midwait imem_addr", 32'(imem_addr), 32'h53);
      checkOutput("midwait busy", 32'(busy), 32'h1);
      reset = 1'b0;
      #1;
      checkOutput("async imem_req", 32'(imem_req), 32'h0);
      checkOutput("async busy", 32'(busy), 32'h0);
      checkOutput("async imem_addr", 32'(imem_addr), 32'h0);
      checkOutput("async if_en", 32'(if_en), 32'h0);
      checkOutput("async if_insn", if_insn, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      imem_rdy = 1'b1;
      #1;
      checkOutput("rerun imem_req", 32'(imem_req), 32'h1);
      checkOutput("rerun imem_addr", 32'(imem_addr), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rerun if_en", 32'(if_en), 32'h1);
      checkOutput("rerun if_pc", 32'(if_pc), 32'h0);
      checkOutput("rerun if_insn", if_insn, 32'h100);
      checkOutput("rerun next addr", 32'(imem_addr), 32'h1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
